axi_ext_mem_slave: RTL and testbench

- Behavioural AXI slave memory for the testbench. It sits directly downstream of the LSU/DMA bridge on its slave‑0 (general external memory) port.
- Accepts single‑beat 64‑bit reads and writes with full IDs and returns responses in order.
- Read latency is programmable and back‑pressure is handled, so the bridge's response muxing and W‑select FIFO see realistic traffic.

---
 rtl/axi_tb_pkg.sv | 17 +
 rtl/tb_sync_fifo.sv | 40 ++++
 rtl/axi_ext_mem_slave.sv | 188 ++++++++++++++++++
 tb/tb_axi_ext_mem_slave.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_tb_pkg.sv
// Shared constants and types for the behavioural external-memory AXI slave.
package axi_tb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest read ID the queue entry carries; wide enough for RD_LAT up to 15.
    localparam int ID_MAX = 8;
    localparam int AGE_W  = 4;

    typedef struct packed {
        logic [ID_MAX-1:0] id;
        logic [31:0]       addr;
        logic [AGE_W-1:0]  age;
    } rd_entry_t;

endpackage

// File: rtl/tb_sync_fifo.sv
// Small synchronous FIFO with extra-bit pointers; storage is reset so the head reads zero after reset.
module tb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push && !full) begin
                mem[wp[AW-1:0]] <= din;
                wp              <= wp + 1'b1;
            end
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head  = mem[rp[AW-1:0]];

endmodule

// File: rtl/axi_ext_mem_slave.sv
// Single-beat 64-bit AXI slave memory with programmable read latency and in-order responses.
module axi_ext_mem_slave
    import axi_tb_pkg::*;
#(
    parameter int          ID_WIDTH   = 8,
    parameter int          MEM_AW     = 12,
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
    parameter int          RD_LAT     = 3,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic                arvalid,
    input  logic [ID_WIDTH-1:0] arid,
    input  logic [31:0]         araddr,
    output logic                arready,
    output logic                rvalid,
    input  logic                rready,
    output logic [63:0]         rdata,
    output logic [ID_WIDTH-1:0] rid,
    output logic [1:0]          rresp,
    output logic                rlast,
    input  logic                awvalid,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic [31:0]         awaddr,
    output logic                awready,
    input  logic                wvalid,
    input  logic [63:0]         wdata,
    input  logic [7:0]          wstrb,
    output logic                wready,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_WIDTH-1:0] bid,
    output logic [1:0]          bresp
);

    localparam int          AP      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [32:0] MEM_END = {1'b0, MEM_BASE} + (33'd8 << MEM_AW);

    function automatic logic in_range(input logic [31:0] a);
        return (a >= MEM_BASE) && ({1'b0, a} < MEM_END);
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] a);
        return MEM_AW'((a - MEM_BASE) >> 3);
    endfunction

    logic [63:0] mem [2**MEM_AW];

    // Readies stay low until the first edge after reset release.
    logic ready_en;
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    // ---------------- read path ----------------
    logic                 ar_push, ar_full, ar_empty, r_load;
    logic [ID_MAX+31:0]   ar_q_head;
    rd_entry_t            ar_head;
    logic [AGE_W-1:0]     age_q [FIFO_DEPTH];
    logic [AP-1:0]        age_wp, age_rp;

    assign arready = ready_en && !ar_full;
    assign ar_push = arvalid && arready;

    tb_sync_fifo #(.WIDTH(ID_MAX + 32), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .push    (ar_push),
        .din     ({ID_MAX'(arid), araddr}),
        .pop     (r_load),
        .head    (ar_q_head),
        .full    (ar_full),
        .empty   (ar_empty)
    );

    always_comb begin
        ar_head.id   = ar_q_head[ID_MAX+31:32];
        ar_head.addr = ar_q_head[31:0];
        ar_head.age  = age_q[age_rp];
    end

    assign r_load = !ar_empty && (ar_head.age >= AGE_W'(RD_LAT - 1)) && (!rvalid || rready);

    // Ages mirror the AR queue slots; a new entry counts its push cycle, so age k means k cycles since handshake.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            age_wp <= '0;
            age_rp <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (age_q[i] < AGE_W'(RD_LAT)) age_q[i] <= age_q[i] + 1'b1;
            if (ar_push) begin
                age_q[age_wp] <= AGE_W'(1);
                age_wp        <= age_wp + 1'b1;
            end
            if (r_load) age_rp <= age_rp + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rid    <= '0;
            rresp  <= RESP_OKAY;
        end else if (r_load) begin
            rvalid <= 1'b1;
            rid    <= ar_head.id[ID_WIDTH-1:0];
            if (in_range(ar_head.addr)) begin
                rdata <= mem[word_idx(ar_head.addr)];
                rresp <= RESP_OKAY;
            end else begin
                rdata <= '0;
                rresp <= RESP_SLVERR;
            end
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

    assign rlast = rvalid;

    // ---------------- write path ----------------
    logic                  aw_full, aw_empty, w_full, w_empty, b_full, b_empty, commit;
    logic [ID_WIDTH+31:0]  aw_head;
    logic [71:0]           w_head;
    logic [ID_WIDTH+1:0]   b_head;
    logic [31:0]           aw_addr;
    logic [ID_WIDTH-1:0]   aw_id;
    logic [63:0]           w_data;
    logic [7:0]            w_strb;

    assign awready = ready_en && !aw_full;
    assign wready  = ready_en && !w_full;
    assign aw_addr = aw_head[31:0];
    assign aw_id   = aw_head[ID_WIDTH+31:32];
    assign w_data  = w_head[71:8];
    assign w_strb  = w_head[7:0];
    assign commit  = !aw_empty && !w_empty && !b_full;

    tb_sync_fifo #(.WIDTH(ID_WIDTH + 32), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .push    (awvalid && awready),
        .din     ({awid, awaddr}),
        .pop     (commit),
        .head    (aw_head),
        .full    (aw_full),
        .empty   (aw_empty)
    );

    tb_sync_fifo #(.WIDTH(72), .DEPTH(FIFO_DEPTH)) u_w_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .push    (wvalid && wready),
        .din     ({wdata, wstrb}),
        .pop     (commit),
        .head    (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    tb_sync_fifo #(.WIDTH(ID_WIDTH + 2), .DEPTH(FIFO_DEPTH)) u_b_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .push    (commit),
        .din     ({aw_id, in_range(aw_addr) ? RESP_OKAY : RESP_SLVERR}),
        .pop     (bvalid && bready),
        .head    (b_head),
        .full    (b_full),
        .empty   (b_empty)
    );

    assign bvalid = !b_empty;
    assign bid    = b_head[ID_WIDTH+1:2];
    assign bresp  = b_head[1:0];

    // Contents survive reset; a same-cycle read of this word samples the old value.
    always_ff @(posedge clk) begin
        if (commit && in_range(aw_addr))
            for (int b = 0; b < 8; b++)
                if (w_strb[b]) mem[word_idx(aw_addr)][8*b +: 8] <= w_data[8*b +: 8];
    end

endmodule

// File: tb/tb_axi_ext_mem_slave.sv
// Randomized scoreboard bench for axi_ext_mem_slave against a word-level memory model.
module tb_axi_ext_mem_slave;

    localparam int          IDW    = 8;
    localparam int          MEM_AW = 12;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          RD_LAT = 3;
    localparam int          DEPTH  = 4;

    logic clk, reset_l;
    logic arvalid, arready, rvalid, rready, rlast;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic [IDW-1:0] arid, rid, awid, bid;
    logic [31:0] araddr, awaddr;
    logic [63:0] rdata, wdata;
    logic [7:0]  wstrb;
    logic [1:0]  rresp, bresp;

    axi_ext_mem_slave #(.ID_WIDTH(IDW), .MEM_AW(MEM_AW), .MEM_BASE(BASE),
                        .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_l(reset_l),
        .arvalid(arvalid), .arid(arid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awid(awid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [IDW-1:0] id; logic [31:0] addr; } a_req_t;
    typedef struct { logic [63:0] d; logic [7:0] s; } w_req_t;
    typedef struct { logic [IDW-1:0] id; logic [63:0] d; logic [1:0] resp; } r_exp_t;
    typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;

    logic [63:0] mdl [int];
    a_req_t ar_q[$], aw_q[$], pend_aw[$];
    w_req_t w_q[$], pend_w[$];
    r_exp_t exp_r[$];
    b_exp_t exp_b[$];
    int ar_acc = 0, aw_acc = 0, w_acc = 0;
    int last_ar_cyc = 0;
    bit rnd_mode = 0;

    function automatic bit rng(input logic [31:0] a);
        return ({32'h0, a} >= {32'h0, BASE}) && ({32'h0, a} < {32'h0, BASE} + (64'd8 << MEM_AW));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 8);
    endfunction

    // Pair AW and W in arrival order; each pair is one write with one B.
    function automatic void pair();
        a_req_t a;
        w_req_t w;
        logic [63:0] v;
        while (pend_aw.size() > 0 && pend_w.size() > 0) begin
            a = pend_aw.pop_front();
            w = pend_w.pop_front();
            if (rng(a.addr)) begin
                v = mdl.exists(widx(a.addr)) ? mdl[widx(a.addr)] : 64'h0;
                for (int b = 0; b < 8; b++) if (w.s[b]) v[8*b +: 8] = w.d[8*b +: 8];
                mdl[widx(a.addr)] = v;
            end
            exp_b.push_back('{a.id, rng(a.addr) ? 2'b00 : 2'b10});
        end
    endfunction

    function automatic r_exp_t rd_expect(input a_req_t a);
        r_exp_t e;
        e.id   = a.id;
        e.resp = rng(a.addr) ? 2'b00 : 2'b10;
        e.d    = (rng(a.addr) && mdl.exists(widx(a.addr))) ? mdl[widx(a.addr)] : 64'h0;
        return e;
    endfunction

    // ---------------- drivers ----------------
    initial begin
        arvalid = 0; arid = '0; araddr = '0;
        forever begin
            @(negedge clk);
            if (reset_l && arvalid && arready && ar_q.size() > 0) begin
                exp_r.push_back(rd_expect(ar_q[0]));
                void'(ar_q.pop_front());
                ar_acc++;
                last_ar_cyc = cyc;
            end
            @(posedge clk); #1;
            if (ar_q.size() > 0) begin arvalid = 1; arid = ar_q[0].id; araddr = ar_q[0].addr; end
            else arvalid = 0;
        end
    end

    initial begin
        awvalid = 0; awid = '0; awaddr = '0;
        forever begin
            @(negedge clk);
            if (reset_l && awvalid && awready && aw_q.size() > 0) begin
                pend_aw.push_back(aw_q.pop_front());
                aw_acc++;
                pair();
            end
            @(posedge clk); #1;
            if (aw_q.size() > 0) begin awvalid = 1; awid = aw_q[0].id; awaddr = aw_q[0].addr; end
            else awvalid = 0;
        end
    end

    initial begin
        wvalid = 0; wdata = '0; wstrb = '0;
        forever begin
            @(negedge clk);
            if (reset_l && wvalid && wready && w_q.size() > 0) begin
                pend_w.push_back(w_q.pop_front());
                w_acc++;
                pair();
            end
            @(posedge clk); #1;
            if (w_q.size() > 0) begin wvalid = 1; wdata = w_q[0].d; wstrb = w_q[0].s; end
            else wvalid = 0;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rnd_mode) begin
            rready = 1'($urandom_range(0, 1));
            bready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitors ----------------
    bit r_stall = 0, b_stall = 0;
    logic [IDW-1:0] p_rid, p_bid;
    logic [63:0] p_rdata;
    logic [1:0] p_rresp, p_bresp;

    initial forever begin
        r_exp_t e;
        @(negedge clk);
        if (!reset_l) begin
            r_stall = 0;
        end else begin
            if (r_stall) begin
                chk("r_hold_valid", 64'(rvalid), 64'd1);
                chk("r_hold_rid", 64'(rid), 64'(p_rid));
                chk("r_hold_rdata", rdata, p_rdata);
                chk("r_hold_rresp", 64'(rresp), 64'(p_rresp));
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected: got rid %h with no read outstanding", rid);
                end else begin
                    e = exp_r.pop_front();
                    chk("rid", 64'(rid), 64'(e.id));
                    chk("rdata", rdata, e.d);
                    chk("rresp", 64'(rresp), 64'(e.resp));
                    chk("rlast", 64'(rlast), 64'd1);
                end
            end
            r_stall = rvalid && !rready;
            p_rid = rid; p_rdata = rdata; p_rresp = rresp;
        end
    end

    initial forever begin
        b_exp_t e;
        @(negedge clk);
        if (!reset_l) begin
            b_stall = 0;
        end else begin
            if (b_stall) begin
                chk("b_hold_valid", 64'(bvalid), 64'd1);
                chk("b_hold_bid", 64'(bid), 64'(p_bid));
                chk("b_hold_bresp", 64'(bresp), 64'(p_bresp));
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got bid %h with no write outstanding", bid);
                end else begin
                    e = exp_b.pop_front();
                    chk("bid", 64'(bid), 64'(e.id));
                    chk("bresp", 64'(bresp), 64'(e.resp));
                end
            end
            b_stall = bvalid && !bready;
            p_bid = bid; p_bresp = bresp;
        end
    end

    // ---------------- helpers ----------------
    task automatic wr(input logic [31:0] a, input logic [IDW-1:0] id, input logic [63:0] d, input logic [7:0] s);
        aw_q.push_back('{id, a});
        w_q.push_back('{d, s});
    endtask

    task automatic rd(input logic [31:0] a, input logic [IDW-1:0] id);
        ar_q.push_back('{id, a});
    endtask

    task automatic drain(input string nm);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (ar_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0 && exp_r.size() == 0 &&
                exp_b.size() == 0 && pend_aw.size() == 0 && pend_w.size() == 0) break;
            @(posedge clk);
        end
        chk({"drain_", nm}, 64'(i < 3000), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int i, lat, n, first, last, acc0, w0;
        reset_l = 0; rready = 0; bready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 64'(arready), 0); chk("rst_awready", 64'(awready), 0);
        chk("rst_wready", 64'(wready), 0);   chk("rst_rvalid", 64'(rvalid), 0);
        chk("rst_bvalid", 64'(bvalid), 0);   chk("rst_rdata", rdata, 0);
        chk("rst_rid", 64'(rid), 0);         chk("rst_rresp", 64'(rresp), 0);
        chk("rst_rlast", 64'(rlast), 0);     chk("rst_bid", 64'(bid), 0);
        chk("rst_bresp", 64'(bresp), 0);
        reset_l = 1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_arready", 64'(arready), 1);
        chk("post_rst_awready", 64'(awready), 1);
        chk("post_rst_wready", 64'(wready), 1);
        @(posedge clk); #1;
        rready = 1; bready = 1;

        // single read with latency measurement
        wr(BASE + 32'h28, 8'h11, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        drain("preload");
        rd(BASE + 32'h28, 8'h3A);
        for (i = 0; i < 50 && ar_q.size() > 0; i++) @(negedge clk);
        for (i = 0; i < 50 && !rvalid; i++) @(negedge clk);
        lat = cyc - last_ar_cyc;
        chk("rd_latency", 64'(lat), 64'(RD_LAT));
        drain("single");

        // back-to-back reads
        for (int k = 1; k <= 4; k++) wr(BASE + 32'(8 * k), 8'(k), {32'hA5A5_0000, 32'(k)}, 8'hFF);
        drain("b2b_pre");
        for (int k = 1; k <= 4; k++) rd(BASE + 32'(8 * k), 8'(k));
        n = 0; first = -1; last = -1;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) begin if (first < 0) first = cyc; last = cyc; n++; end
        end
        chk("b2b_count", 64'(n), 4);
        chk("b2b_span", 64'(last - first), 3);
        drain("b2b");

        // fill the read side under back-pressure
        rready = 0;
        acc0 = ar_acc;
        for (int k = 0; k < 6; k++) rd(BASE + 32'(8 * (1 + k % 4)), 8'(16 + k));
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("ar_full_arready", 64'(arready), 0);
        chk("ar_full_accepted", 64'(ar_acc - acc0), 64'(DEPTH + 1));
        @(posedge clk); #1;
        rready = 1;
        drain("ar_full");

        // W ahead of AW with partial strobe
        wr(BASE + 32'h40, 8'h06, 64'h0, 8'hFF);
        drain("zero40");
        w_q.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 8'h0F});
        repeat (2) @(posedge clk);
        aw_q.push_back('{8'h07, BASE + 32'h40});
        drain("w_early");
        rd(BASE + 32'h40, 8'h21);
        drain("rd40");

        // out of range write must not alias onto word 0
        wr(BASE + 32'h0, 8'h05, 64'h0123_4567_89AB_CDEF, 8'hFF);
        drain("w0");
        wr(BASE + 32'h8000, 8'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        rd(BASE + 32'h8000, 8'h40);
        drain("oor");
        rd(BASE + 32'h0, 8'h41);
        drain("oor_check");

        // B back-pressure fills B, AW and W queues
        bready = 0;
        acc0 = aw_acc; w0 = w_acc;
        for (int k = 0; k < 10; k++) wr(BASE + 32'(8 * (16 + k)), 8'(k), {$urandom, $urandom}, 8'hFF);
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("bfull_bvalid", 64'(bvalid), 1);
        chk("bfull_wready", 64'(wready), 0);
        chk("bfull_awready", 64'(awready), 0);
        chk("bfull_w_acc", 64'(w_acc - w0), 64'(2 * DEPTH));
        chk("bfull_aw_acc", 64'(aw_acc - acc0), 64'(2 * DEPTH));
        @(posedge clk); #1;
        bready = 1;
        drain("bfull");
        rnd_mode = 1;
        for (int k = 0; k < 10; k++) rd(BASE + 32'(8 * (16 + k)), 8'(k + 8'h50));
        drain("bfull_rd");
        rnd_mode = 0;
        @(posedge clk); #1;

        // reset with traffic outstanding
        rready = 0; bready = 0;
        rd(BASE + 32'h8, 8'h61);
        rd(BASE + 32'h10, 8'h62);
        wr(BASE + 32'(8 * 100), 8'h63, 64'h1, 8'hFF);
        for (i = 0; i < 20 && ar_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        reset_l = 0;
        #1;
        chk("midrst_rvalid", 64'(rvalid), 0);
        chk("midrst_bvalid", 64'(bvalid), 0);
        chk("midrst_arready", 64'(arready), 0);
        ar_q.delete(); aw_q.delete(); w_q.delete(); pend_aw.delete(); pend_w.delete();
        exp_r.delete(); exp_b.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_l = 1;
        rready = 1; bready = 1;
        n = 0;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid || bvalid) n++;
        end
        chk("midrst_no_stale", 64'(n), 0);

        // random mixed traffic: writes to one region, reads from another, then read back
        for (int k = 0; k < 16; k++) wr(BASE + 32'(8 * (200 + k)), 8'(k), {$urandom, $urandom}, 8'hFF);
        for (int k = 0; k < 8; k++)  wr(BASE + 32'(8 * (300 + k)), 8'(k), {$urandom, $urandom}, 8'hFF);
        drain("rnd_pre");
        rnd_mode = 1;
        for (int k = 0; k < 200; k++) begin
            logic [31:0] a;
            if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 9) == 0) a = BASE + 32'h8000 + 32'(8 * $urandom_range(0, 63));
                else a = BASE + 32'(8 * (200 + $urandom_range(0, 15)));
                wr(a | 32'($urandom_range(0, 7)), 8'($urandom), {$urandom, $urandom}, 8'($urandom));
            end else begin
                if ($urandom_range(0, 9) == 0) a = BASE + 32'h8000 + 32'(8 * $urandom_range(0, 63));
                else a = BASE + 32'(8 * (300 + $urandom_range(0, 7)));
                rd(a | 32'($urandom_range(0, 7)), 8'($urandom));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain("rnd_mix");
        for (int k = 0; k < 100; k++) begin
            rd(BASE + 32'(8 * (200 + $urandom_range(0, 15))) | 32'($urandom_range(0, 7)), 8'($urandom));
            repeat ($urandom_range(0, 1)) @(posedge clk);
        end
        drain("rnd_rd");
        rnd_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
